operand_issue: RTL and testbench
================================

Name: operand_issue

Overview:
- Sits between the decoder and the execute stage, and is the requesting side of the register file's two read ports.
- For each decoded instruction it drives r1/r2 requests, checks a per-register pending-write scoreboard, and stalls until both operands are valid.
- It then registers the operands into a valid/ready output slot toward EX.
- Writebacks to the register file also retire scoreboard entries. The register file forwards same-cycle write data, so a matching writeback clears a hazard in that same cycle.

Parameters:
REG_NUM  32  number of architectural registers (x0 hardwired zero)
ADDR_W  5  register address width
DATA_W  32  register data width
PEND_W  2  width of per-register pending-write counter
INFO_W  32  width of opaque decoded payload passed through to EX

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
rdy  in  1  global enable; low freezes all state
flush  in  1  pipeline flush (branch mispredict)
in_valid  in  1  decoded instruction present
in_ready  out  1  instruction accepted this cycle
in_rs1_en / in_rs2_en  in  1 each  source operand used
in_rs1 / in_rs2  in  ADDR_W each  source register
in_rd_en  in  1  instruction writes rd
in_rd  in  ADDR_W  destination register
in_info  in  INFO_W  passthrough payload
r1_req / r2_req  out  1 each  register file read requests
r1_addr / r2_addr  out  ADDR_W each  read addresses
r1_data / r2_data  in  DATA_W each  read data (combinational, forwarded)
wb_req  in  1  writeback valid (same signal as the register file write request)
wb_addr  in  ADDR_W  writeback register
out_valid  out  1  operands valid to EX
out_ready  in  1  EX accepts
out_op1 / out_op2  out  DATA_W each  operand values
out_rd_en / out_rd  out  1 / ADDR_W  destination
out_info  out  INFO_W  payload
stall_cycles  out  32  hazard stall counter (see Optional Feature)

Behaviour:
- Reset (async, rst=1): all pend[] = 0; out_valid = 0; out_op1/op2/out_rd/out_info/out_rd_en = 0; stall_cycles = 0.
- Read requests are combinational:
  - r1_req = rdy & in_valid & in_rs1_en; r1_addr = in_rs1. r2 is analogous.
  - When a request is low, its address is driven 0.
- Per-source hazard: enable & rs != 0 & pend[rs] != 0, except when wb_req & wb_addr == rs & pend[rs] == 1. In that case the forwarded r*_data is used and there is no hazard.
- Structural hazard: in_rd_en & in_rd != 0 & pend[in_rd] is all-ones (saturated).
- slot_free = !out_valid | out_ready.
- Issue condition: in_ready = rdy & !rst & !flush & in_valid & slot_free & no hazard of either kind.
- On issue, the output slot loads on the next edge:
  - out_op1 = rs1_en ? r1_data : 0; out_op2 likewise.
  - out_rd_en, out_rd, out_info are copied from the input; out_valid = 1.
- Latency: 1 cycle from acceptance to out_valid with no hazard.
- Slot handshake:
  - If out_valid & out_ready with no new issue, out_valid is cleared.
  - While out_valid & !out_ready, all out_* signals are held stable.
- Scoreboard update each enabled cycle:
  - +1 on pend[in_rd] when issuing with in_rd_en & in_rd != 0.
  - -1 on pend[wb_addr] when wb_req & wb_addr != 0 & pend[wb_addr] != 0.
  - Simultaneous inc and dec on the same register: net unchanged.
  - Writeback to a register with pend == 0 is ignored (no underflow).
  - x0 never tracked.
- flush=1 (synchronous, priority over everything except rst):
  - Clears out_valid and all pend[]; no issue that cycle; wb_req that cycle ignored.
  - Downstream stages flush in the same cycle.
- rdy=0: no state changes; in_ready = 0; r1_req = r2_req = 0; outputs hold.
- An instruction reading and writing the same register (e.g. rd = rs1) checks the hazard against the pre-increment count.

Optional Feature:
- Macro OPERAND_ISSUE_STALL_CNT_EN.
- Defined: stall_cycles is a 32-bit counter, +1 each cycle with rdy & in_valid & !flush & slot_free & (operand or structural hazard). It wraps at 2^32 and is cleared by rst only.
- Undefined: stall_cycles is tied to 0 and no counter is built.

Test Plan:
- Reset, then issue ADD rs1=1, rs2=2, rd=3 with regfile returning 0x11/0x22, out_ready=1 -> next cycle out_valid=1, out_op1=0x11, out_op2=0x22, out_rd=3; pend[3]=1.
- RAW: issue rd=5, then rs1=5 with no writeback -> in_ready=0 for 3 cycles (stall_cycles=3 when enabled). wb_req=1, wb_addr=5, r1_data=0xDEAD in the same cycle -> accepted that cycle, out_op1=0xDEAD.
- Saturation: 3 issues with rd=7 and no writeback (PEND_W=2) -> 4th rd=7 issue stalls; one wb to 7 -> 4th accepted the same cycle.
- Backpressure: out_ready=0 with out_valid=1 -> in_ready=0, out_* unchanged 4 cycles. out_ready=1 -> next instruction loads next edge.
- Flush with pend[3]=2 and out_valid=1 -> next cycle out_valid=0, pend all 0. A following read of x3 issues without stall.
- x0 and rdy: rd=0 issue leaves pend unchanged. rdy=0 while in_valid=1 -> r1_req=0, in_ready=0, no state change. Async rst mid-stall -> out_valid=0 immediately.

Source files
------------

// File: rtl/operand_issue.sv
// Operand issue stage: requests register-file reads, tracks pending writes per
// register, and hands stall-free operands to EX. `OPERAND_ISSUE_STALL_CNT_EN adds a hazard stall counter.
module operand_issue #(
  parameter int REG_NUM = 32,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int PEND_W  = 2,
  parameter int INFO_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_rs1_en,
  input  logic              in_rs2_en,
  input  logic [ADDR_W-1:0] in_rs1,
  input  logic [ADDR_W-1:0] in_rs2,
  input  logic              in_rd_en,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [INFO_W-1:0] in_info,
  output logic              r1_req,
  output logic              r2_req,
  output logic [ADDR_W-1:0] r1_addr,
  output logic [ADDR_W-1:0] r2_addr,
  input  logic [DATA_W-1:0] r1_data,
  input  logic [DATA_W-1:0] r2_data,
  input  logic              wb_req,
  input  logic [ADDR_W-1:0] wb_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_op1,
  output logic [DATA_W-1:0] out_op2,
  output logic              out_rd_en,
  output logic [ADDR_W-1:0] out_rd,
  output logic [INFO_W-1:0] out_info,
  output logic [31:0]       stall_cycles
);

  // Handshake: a transfer happens on a clock edge where valid & ready are both
  // high; the producer holds valid and its payload stable until that edge, and
  // valid never depends combinationally on ready.

  logic [PEND_W-1:0] pend [REG_NUM];

  logic              rs1_pend_nz;
  logic              rs2_pend_nz;
  logic              rs1_wb_clears;
  logic              rs2_wb_clears;
  logic              rs1_haz;
  logic              rs2_haz;
  logic              rd_saturated;
  logic              struct_haz;
  logic              op_haz;
  logic              slot_free;
  logic              issue;
  logic [REG_NUM-1:0] inc_hit;
  logic [REG_NUM-1:0] dec_hit;

  assign r1_req  = rdy & in_valid & in_rs1_en;
  assign r2_req  = rdy & in_valid & in_rs2_en;
  assign r1_addr = r1_req ? in_rs1 : '0;
  assign r2_addr = r2_req ? in_rs2 : '0;

  // A single outstanding write retiring this cycle is covered by the forwarded read data.
  assign rs1_pend_nz   = pend[in_rs1] != '0;
  assign rs2_pend_nz   = pend[in_rs2] != '0;
  assign rs1_wb_clears = wb_req & (wb_addr == in_rs1) & (pend[in_rs1] == PEND_W'(1));
  assign rs2_wb_clears = wb_req & (wb_addr == in_rs2) & (pend[in_rs2] == PEND_W'(1));
  assign rs1_haz = in_rs1_en & (in_rs1 != '0) & rs1_pend_nz & ~rs1_wb_clears;
  assign rs2_haz = in_rs2_en & (in_rs2 != '0) & rs2_pend_nz & ~rs2_wb_clears;
  assign op_haz  = rs1_haz | rs2_haz;

  // A saturated counter that retires in the same cycle nets to no change, so it may issue.
  assign rd_saturated = pend[in_rd] == {PEND_W{1'b1}};
  assign struct_haz   = in_rd_en & (in_rd != '0) & rd_saturated &
                        ~(wb_req & (wb_addr == in_rd));

  assign slot_free = ~out_valid | out_ready;
  assign in_ready  = rdy & ~rst & ~flush & in_valid & slot_free & ~op_haz & ~struct_haz;
  assign issue     = in_ready;

  always_comb begin
    inc_hit = '0;
    dec_hit = '0;
    for (int i = 1; i < REG_NUM; i++) begin
      inc_hit[i] = issue & in_rd_en & (in_rd == ADDR_W'(i));
      dec_hit[i] = wb_req & (wb_addr == ADDR_W'(i)) & (pend[i] != '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) pend[i] <= '0;
      out_valid <= 1'b0;
      out_op1   <= '0;
      out_op2   <= '0;
      out_rd_en <= 1'b0;
      out_rd    <= '0;
      out_info  <= '0;
    end else if (flush) begin
      for (int i = 0; i < REG_NUM; i++) pend[i] <= '0;
      out_valid <= 1'b0;
    end else if (rdy) begin
      for (int i = 1; i < REG_NUM; i++) begin
        if (inc_hit[i] && !dec_hit[i]) pend[i] <= pend[i] + PEND_W'(1);
        else if (dec_hit[i] && !inc_hit[i]) pend[i] <= pend[i] - PEND_W'(1);
      end
      if (issue) begin
        out_valid <= 1'b1;
        out_op1   <= in_rs1_en ? r1_data : '0;
        out_op2   <= in_rs2_en ? r2_data : '0;
        out_rd_en <= in_rd_en;
        out_rd    <= in_rd;
        out_info  <= in_info;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef OPERAND_ISSUE_STALL_CNT_EN
  logic        stall_event;
  logic [31:0] stall_q;

  assign stall_event = rdy & in_valid & ~flush & slot_free & (op_haz | struct_haz);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_q <= '0;
    else if (stall_event) stall_q <= stall_q + 32'd1;
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_operand_issue.sv
// Self-checking bench for operand_issue: directed hazard/flush/reset steps, then
// random traffic scored against a counter-array plus slot-queue reference model.
module tb_operand_issue;
  localparam int REG_NUM  = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int INFO_W   = 32;
  localparam int PEND_MAX = 3;
  localparam int SLOT_W   = 2 * DATA_W + 1 + ADDR_W + INFO_W;
`ifdef OPERAND_ISSUE_STALL_CNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic              clk, rst, rdy, flush;
  logic              in_valid, in_ready;
  logic              in_rs1_en, in_rs2_en, in_rd_en;
  logic [ADDR_W-1:0] in_rs1, in_rs2, in_rd;
  logic [INFO_W-1:0] in_info;
  logic              r1_req, r2_req;
  logic [ADDR_W-1:0] r1_addr, r2_addr;
  logic [DATA_W-1:0] r1_data, r2_data;
  logic              wb_req;
  logic [ADDR_W-1:0] wb_addr;
  logic              out_valid, out_ready, out_rd_en;
  logic [DATA_W-1:0] out_op1, out_op2;
  logic [ADDR_W-1:0] out_rd;
  logic [INFO_W-1:0] out_info;
  logic [31:0]       stall_cycles;

  operand_issue #(.REG_NUM(REG_NUM), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PEND_W(2), .INFO_W(INFO_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_en(in_rs1_en), .in_rs2_en(in_rs2_en), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_rd_en(in_rd_en), .in_rd(in_rd), .in_info(in_info),
    .r1_req(r1_req), .r2_req(r2_req), .r1_addr(r1_addr), .r2_addr(r2_addr),
    .r1_data(r1_data), .r2_data(r2_data),
    .wb_req(wb_req), .wb_addr(wb_addr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op1(out_op1), .out_op2(out_op2), .out_rd_en(out_rd_en), .out_rd(out_rd),
    .out_info(out_info), .stall_cycles(stall_cycles)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert;
  int n_fail;

  // reference model: outstanding-write count per register, output slot as a depth-1 queue
  int                pend_m [REG_NUM];
  logic [SLOT_W-1:0] exp_q [$];
  logic [31:0]       stall_m;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < REG_NUM; i++) pend_m[i] = 0;
    exp_q.delete();
    stall_m = 32'd0;
  endfunction

  function automatic bit src_haz(input bit en, input logic [ADDR_W-1:0] rs);
    if (!en || rs == 0 || pend_m[rs] == 0) return 1'b0;
    if (wb_req && wb_addr == rs && pend_m[rs] == 1) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit any_haz();
    bit sat;
    sat = in_rd_en && in_rd != 0 && pend_m[in_rd] == PEND_MAX && !(wb_req && wb_addr == in_rd);
    return src_haz(in_rs1_en, in_rs1) || src_haz(in_rs2_en, in_rs2) || sat;
  endfunction

  function automatic bit model_slot_free();
    return exp_q.size() == 0 || out_ready;
  endfunction

  function automatic bit model_ready();
    return rdy && !rst && !flush && in_valid && model_slot_free() && !any_haz();
  endfunction

  task automatic check_slot();
    check("out_valid", 128'(out_valid), 128'(exp_q.size() != 0));
    if (exp_q.size() != 0)
      check("out_slot", 128'({out_op1, out_op2, out_rd_en, out_rd, out_info}), 128'(exp_q[0]));
    check("stall_cycles", 128'(stall_cycles), 128'(STALL_EN ? stall_m : 32'd0));
  endtask

  // driver: called just after a negedge with inputs already applied
  task automatic cycle();
    bit go, stall_ev, dec;
    logic [SLOT_W-1:0] nxt;
    logic [ADDR_W-1:0] exp_a1, exp_a2;
    #1;
    go       = model_ready();
    stall_ev = rdy && in_valid && !flush && model_slot_free() && any_haz();
    exp_a1   = (rdy && in_valid && in_rs1_en) ? in_rs1 : '0;
    exp_a2   = (rdy && in_valid && in_rs2_en) ? in_rs2 : '0;
    check("r1_req", 128'(r1_req), 128'(rdy && in_valid && in_rs1_en));
    check("r2_req", 128'(r2_req), 128'(rdy && in_valid && in_rs2_en));
    check("r1_addr", 128'(r1_addr), 128'(exp_a1));
    check("r2_addr", 128'(r2_addr), 128'(exp_a2));
    check("in_ready", 128'(in_ready), 128'(go));
    nxt = {(in_rs1_en ? r1_data : 32'h0), (in_rs2_en ? r2_data : 32'h0), in_rd_en, in_rd, in_info};
    @(posedge clk);
    if (flush) begin
      for (int i = 0; i < REG_NUM; i++) pend_m[i] = 0;
      exp_q.delete();
    end else if (rdy) begin
      if (stall_ev) stall_m = stall_m + 32'd1;
      dec = wb_req && wb_addr != 0 && pend_m[wb_addr] > 0;
      if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
      if (go) exp_q.push_back(nxt);
      if (go && in_rd_en && in_rd != 0) pend_m[in_rd] = pend_m[in_rd] + 1;
      if (dec) pend_m[wb_addr] = pend_m[wb_addr] - 1;
    end
    #1;
    check_slot();
    @(negedge clk);
  endtask

  task automatic set_idle();
    rdy = 1'b1; flush = 1'b0; in_valid = 1'b0;
    in_rs1_en = 1'b0; in_rs2_en = 1'b0; in_rs1 = '0; in_rs2 = '0;
    in_rd_en = 1'b0; in_rd = '0; in_info = '0;
    r1_data = '0; r2_data = '0; wb_req = 1'b0; wb_addr = '0; out_ready = 1'b1;
  endtask

  task automatic set_instr(input bit e1, input logic [ADDR_W-1:0] a1, input bit e2,
                           input logic [ADDR_W-1:0] a2, input bit ed,
                           input logic [ADDR_W-1:0] d, input logic [INFO_W-1:0] info);
    in_valid = 1'b1;
    in_rs1_en = e1; in_rs1 = a1; in_rs2_en = e2; in_rs2 = a2;
    in_rd_en = ed; in_rd = d; in_info = info;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    set_idle();
    model_reset();
    rst = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_out_data", 128'({out_op1, out_op2, out_rd_en, out_rd, out_info}), 128'(0));
    check("rst_stall", 128'(stall_cycles), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // basic issue
    set_instr(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 32'hA001);
    r1_data = 32'h11; r2_data = 32'h22;
    cycle();
    check("add_op1", 128'(out_op1), 128'(32'h11));
    check("add_op2", 128'(out_op2), 128'(32'h22));
    check("add_rd", 128'(out_rd), 128'(5'd3));
    set_idle();
    cycle();

    // RAW on x5, retired by a forwarded writeback
    set_instr(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 32'hA002);
    cycle();
    set_instr(1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 32'hA003);
    repeat (3) cycle();
    check("raw_stall", 128'(in_ready), 128'(0));
    check("raw_stall_cnt", 128'(stall_cycles), 128'(STALL_EN ? 32'd3 : 32'd0));
    wb_req = 1'b1; wb_addr = 5'd5; r1_data = 32'hDEAD;
    #1 check("raw_wb_ready", 128'(in_ready), 128'(1));
    cycle();
    check("raw_wb_op1", 128'(out_op1), 128'(32'hDEAD));

    // saturation of x7
    set_idle();
    set_instr(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7, 32'hA007);
    repeat (3) cycle();
    cycle();
    check("sat_stall", 128'(in_ready), 128'(0));
    wb_req = 1'b1; wb_addr = 5'd7;
    #1 check("sat_wb_ready", 128'(in_ready), 128'(1));
    cycle();

    // backpressure
    set_idle();
    out_ready = 1'b0;
    set_instr(1'b1, 5'd1, 1'b0, 5'd0, 1'b0, 5'd0, 32'hB001);
    r1_data = 32'h55;
    repeat (4) cycle();
    check("bp_hold_rd", 128'(out_rd), 128'(5'd7));
    check("bp_hold_info", 128'(out_info), 128'(32'hA007));
    check("bp_in_ready", 128'(in_ready), 128'(0));
    out_ready = 1'b1;
    cycle();
    check("bp_release_op1", 128'(out_op1), 128'(32'h55));

    // flush with x3 pending twice and the slot occupied
    set_idle();
    set_instr(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3, 32'hC001);
    cycle();
    set_idle();
    out_ready = 1'b0; flush = 1'b1;
    cycle();
    check("flush_out_valid", 128'(out_valid), 128'(0));
    flush = 1'b0;
    set_instr(1'b1, 5'd3, 1'b1, 5'd7, 1'b0, 5'd0, 32'hC002);
    #1 check("flush_no_stall", 128'(in_ready), 128'(1));
    cycle();

    // x0 and rd == rs1
    set_idle();
    set_instr(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 32'hD000);
    cycle();
    set_instr(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 32'hD001);
    cycle();
    set_instr(1'b1, 5'd4, 1'b0, 5'd0, 1'b1, 5'd4, 32'hD004);
    cycle();
    cycle();
    check("rd_eq_rs_stall", 128'(in_ready), 128'(0));

    // rdy low freezes everything
    rdy = 1'b0;
    cycle();
    check("rdy_r1_req", 128'(r1_req), 128'(0));

    // async reset during a stall
    set_idle();
    out_ready = 1'b0;
    set_instr(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9, 32'hE009);
    cycle();
    set_instr(1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0, 32'hE00A);
    cycle();
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", 128'(out_valid), 128'(0));
    check("arst_out_op1", 128'(out_op1), 128'(0));
    check("arst_in_ready", 128'(in_ready), 128'(0));
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cycle();

    // randomized traffic on a small register window to provoke hazards
    for (int n = 0; n < 800; n++) begin
      rdy       = ($urandom_range(0, 9) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_rs1_en = ($urandom_range(0, 3) != 0);
      in_rs2_en = ($urandom_range(0, 1) != 0);
      in_rd_en  = ($urandom_range(0, 3) != 0);
      in_rs1    = ADDR_W'($urandom_range(0, 7));
      in_rs2    = ADDR_W'($urandom_range(0, 7));
      in_rd     = ADDR_W'($urandom_range(0, 7));
      in_info   = $urandom;
      r1_data   = $urandom;
      r2_data   = $urandom;
      wb_req    = ($urandom_range(0, 9) < 4);
      wb_addr   = ADDR_W'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 9) < 7);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
